// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings,
// the stored entry layout and the opcode legality check.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;

  // Entry as held in the FIFO, most significant field first.
  typedef struct packed {
    logic [2:0]           opcode;
    logic [ALU_WIDTH-1:0] result;
    logic                 carry;
    logic                 zero;
    logic                 illegal;
  } aluEntry_t;

  // Only the four arithmetic/logic opcodes are defined; 1xx are illegal.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_SUB, OP_ADD, OP_OR, OP_AND: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with occupancy count. The read port is driven
// straight from storage; while empty it keeps showing the last-popped slot.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     rdEn,
  output logic [DATA_W-1:0]        rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wrPtr_r;
  logic [PTR_W-1:0]  rdPtr_r;
  logic [PTR_W-1:0]  headIdx_s;
  logic [CW-1:0]     count_r;
  logic              push_s;
  logic              pop_s;

  assign full   = (count_r == FULL_CNT);
  assign empty  = (count_r == {CW{1'b0}});
  assign push_s = wrEn && !full;
  assign pop_s  = rdEn && !empty;
  assign count  = count_r;

  // Head slot; when empty, look one slot back so the last-popped entry stays visible
  always_comb begin
    if (empty) begin
      headIdx_s = rdPtr_r - PTR_W'(1);
    end else begin
      headIdx_s = rdPtr_r;
    end
  end

  assign rdData = mem_r[headIdx_s];

  // Storage: cleared on reset so the outputs read zero until first use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wrPtr_r] <= wrData;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_r <= {PTR_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: derives carry/zero/illegal flags, replaces undefined
// results of illegal opcodes with zero, queues entries and counts illegals.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [2:0]             OpCode,
  input  logic [WIDTH-1:0]       Result,
  input  logic                   Cout,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [2:0]             OutOpCode,
  output logic [WIDTH-1:0]       OutResult,
  output logic                   OutCarry,
  output logic                   OutZero,
  output logic                   OutIllegal,
  output logic [$clog2(DEPTH):0] Count,
  output logic [CNT_W-1:0]       IllegalCount
);

  localparam int ENTRY_W = WIDTH + 6;

  logic [WIDTH-1:0]   entryResult_s;
  logic               entryCarry_s;
  logic               entryZero_s;
  logic               entryIllegal_s;
  logic [ENTRY_W-1:0] entryIn_s;
  logic [ENTRY_W-1:0] entryOut_s;
  logic               fifoFull_s;
  logic               fifoEmpty_s;
  logic               push_s;
  logic [CNT_W-1:0]   illegalCount_r;

  // Entry formation; illegal opcodes never let the raw Result through
  always_comb begin
    entryResult_s  = {WIDTH{1'b0}};
    entryCarry_s   = 1'b0;
    entryZero_s    = 1'b0;
    entryIllegal_s = 1'b1;
    if (is_legal_op(OpCode)) begin
      entryResult_s  = Result;
      entryZero_s    = (Result == {WIDTH{1'b0}});
      entryIllegal_s = 1'b0;
      case (OpCode)
        OP_SUB, OP_ADD: entryCarry_s = Cout;
        default:        entryCarry_s = 1'b0;
      endcase
    end else begin
      entryResult_s  = {WIDTH{1'b0}};
      entryCarry_s   = 1'b0;
      entryZero_s    = 1'b0;
      entryIllegal_s = 1'b1;
    end
  end

  assign entryIn_s = {OpCode, entryResult_s, entryCarry_s, entryZero_s, entryIllegal_s};
  assign push_s    = InValid && !fifoFull_s;
  assign InReady   = !fifoFull_s;
  assign OutValid  = !fifoEmpty_s;
  assign {OutOpCode, OutResult, OutCarry, OutZero, OutIllegal} = entryOut_s;
  assign IllegalCount = illegalCount_r;

  alu_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk    (Clk),
    .rst    (Reset),
    .wrEn   (InValid),
    .wrData (entryIn_s),
    .rdEn   (OutReady),
    .rdData (entryOut_s),
    .count  (Count),
    .full   (fifoFull_s),
    .empty  (fifoEmpty_s)
  );

  // Saturating debug count of accepted illegal-opcode entries
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      illegalCount_r <= {CNT_W{1'b0}};
    end else if (push_s && entryIllegal_s && (illegalCount_r != {CNT_W{1'b1}})) begin
      illegalCount_r <= illegalCount_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_alu_result_stage;

  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [2:0] OpCode = 3'b000;
  logic [3:0] Result = 4'h0;
  logic       Cout = 1'b0;
  logic       OutValid;
  logic       OutReady = 1'b0;
  logic [2:0] OutOpCode;
  logic [3:0] OutResult;
  logic       OutCarry;
  logic       OutZero;
  logic       OutIllegal;
  logic [2:0] Count;
  logic [7:0] IllegalCount;

  alu_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .OpCode(OpCode), .Result(Result), .Cout(Cout),
    .OutValid(OutValid), .OutReady(OutReady), .OutOpCode(OutOpCode),
    .OutResult(OutResult), .OutCarry(OutCarry), .OutZero(OutZero),
    .OutIllegal(OutIllegal), .Count(Count), .IllegalCount(IllegalCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   illCnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Expected entry straight from the opcode rules.
  function automatic exp_t form(input logic [2:0] op, input logic [3:0] r, input logic co);
    exp_t e;
    e.op = op;
    if (op >= 3'd4) begin
      e.res = 4'h0; e.c = 1'b0; e.z = 1'b0; e.ill = 1'b1;
    end else begin
      e.res = r;
      e.c   = (op == 3'b000 || op == 3'b001) ? co : 1'b0;
      e.z   = (r == 4'h0);
      e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [7:0] expIllCnt();
    return (illCnt > 255) ? 8'd255 : 8'(illCnt);
  endfunction

  // Advance one clock (we sit at posedge+1) and update the model.
  task automatic step();
    bit   push;
    bit   pop;
    exp_t e;
    push = InValid && (q.size() < DEPTH);
    pop  = OutReady && (q.size() > 0);
    e    = form(OpCode, Result, Cout);
    @(posedge Clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      if (e.ill) illCnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || IllegalCount !== 8'd0 ||
        OutOpCode !== 3'd0 || OutResult !== 4'd0 || OutCarry !== 1'b0 ||
        OutZero !== 1'b0 || OutIllegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: Count=%0d OutValid=%b IllCnt=%0d Out=%h/%h/%b%b%b, want all 0",
               Count, OutValid, IllegalCount, OutOpCode, OutResult, OutCarry, OutZero, OutIllegal);
    end
    @(negedge Clk);
    Reset = 1'b0;
    q.delete(); illCnt = 0;
    @(posedge Clk);
    #1;
    vectors++;
    if (InReady !== 1'b1 || Count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: InReady=%b Count=%0d, want 1 and 0", InReady, Count);
    end
  endtask

  task automatic test_add();
    OutReady = 1'b1;
    InValid = 1'b1; OpCode = 3'b001; Result = 4'h1; Cout = 1'b1;
    step();
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b1 || OutResult !== 4'h1 || OutCarry !== 1'b1 ||
        OutZero !== 1'b0 || OutIllegal !== 1'b0 || OutOpCode !== 3'b001) begin
      miscompares++;
      $display("FAIL add: V=%b op=%h res=%h c=%b z=%b ill=%b, want 1 1 1 1 0 0",
               OutValid, OutOpCode, OutResult, OutCarry, OutZero, OutIllegal);
    end
    step();
  endtask

  task automatic test_sub_or();
    OutReady = 1'b1;
    InValid = 1'b1; OpCode = 3'b000; Result = 4'h0; Cout = 1'b1;
    step();
    OpCode = 3'b010; Result = 4'hF; Cout = 1'b1;
    vectors++;
    if (OutValid !== 1'b1 || OutResult !== 4'h0 || OutZero !== 1'b1 || OutCarry !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_zero: V=%b res=%h z=%b c=%b, want 1 0 1 1",
               OutValid, OutResult, OutZero, OutCarry);
    end
    step();
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b1 || OutResult !== 4'hF || OutZero !== 1'b0 || OutCarry !== 1'b0) begin
      miscompares++;
      $display("FAIL or_flags: V=%b res=%h z=%b c=%b, want 1 f 0 0",
               OutValid, OutResult, OutZero, OutCarry);
    end
    step();
  endtask

  task automatic test_illegal();
    OutReady = 1'b1;
    InValid = 1'b1; OpCode = 3'b101; Result = 4'bzzzz; Cout = 1'b1;
    step();
    InValid = 1'b0; Result = 4'h0;
    vectors++;
    if (OutValid !== 1'b1 || OutResult !== 4'h0 || OutIllegal !== 1'b1 ||
        OutCarry !== 1'b0 || OutZero !== 1'b0 || IllegalCount !== 8'd1) begin
      miscompares++;
      $display("FAIL illegal: V=%b res=%h ill=%b c=%b z=%b cnt=%0d, want 1 0 1 0 0 1",
               OutValid, OutResult, OutIllegal, OutCarry, OutZero, IllegalCount);
    end
    step();
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      InValid = 1'b1; OpCode = 3'b001; Result = 4'(v); Cout = 1'b0;
      step();
    end
    vectors++;
    if (Count !== 3'd4 || InReady !== 1'b0) begin
      miscompares++;
      $display("FAIL full: Count=%0d InReady=%b, want 4 0", Count, InReady);
    end
    Result = 4'd5;
    step();
    vectors++;
    if (Count !== 3'd4 || OutResult !== 4'd1) begin
      miscompares++;
      $display("FAIL refused_push: Count=%0d head=%0d, want 4 1", Count, OutResult);
    end
    OutReady = 1'b1;
    step();
    vectors++;
    if (Count !== 3'd3 || InReady !== 1'b1 || OutResult !== 4'd2) begin
      miscompares++;
      $display("FAIL pop_when_full: Count=%0d InReady=%b head=%0d, want 3 1 2",
               Count, InReady, OutResult);
    end
    step();
    InValid = 1'b0;
    vectors++;
    if (Count !== 3'd3) begin
      miscompares++;
      $display("FAIL push_pop_same: Count=%0d, want 3", Count);
    end
    for (int v = 3; v <= 5; v++) begin
      vectors++;
      if (OutValid !== 1'b1 || OutResult !== 4'(v)) begin
        miscompares++;
        $display("FAIL order: V=%b head=%0d, want 1 %0d", OutValid, OutResult, v);
      end
      step();
    end
    vectors++;
    if (OutValid !== 1'b0 || Count !== 3'd0) begin
      miscompares++;
      $display("FAIL drained: V=%b Count=%0d, want 0 0", OutValid, Count);
    end
  endtask

  task automatic test_random();
    exp_t h;
    for (int i = 0; i < 400; i++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      OpCode   = 3'($urandom_range(0, 7));
      Result   = 4'($urandom_range(0, 15));
      Cout     = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (Count !== 3'(q.size()) || InReady !== (q.size() < DEPTH) ||
          OutValid !== (q.size() > 0) || IllegalCount !== expIllCnt()) begin
        miscompares++;
        $display("FAIL random_status@%0d: Count=%0d InReady=%b V=%b Ill=%0d, want %0d %b %b %0d",
                 i, Count, InReady, OutValid, IllegalCount, q.size(),
                 q.size() < DEPTH, q.size() > 0, expIllCnt());
      end
      if (q.size() > 0) begin
        h = q[0];
        vectors++;
        if ({OutOpCode, OutResult, OutCarry, OutZero, OutIllegal} !== h) begin
          miscompares++;
          $display("FAIL random_head@%0d: got %h/%h/%b%b%b, want %h/%h/%b%b%b", i,
                   OutOpCode, OutResult, OutCarry, OutZero, OutIllegal,
                   h.op, h.res, h.c, h.z, h.ill);
        end
      end
    end
    InValid = 1'b0; OutReady = 1'b1;
    repeat (DEPTH) step();
  endtask

  task automatic test_saturation();
    OutReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      InValid = 1'b1;
      OpCode  = 3'($urandom_range(4, 7));
      Result  = 4'($urandom_range(0, 15));
      step();
      if (i == 99) begin
        vectors++;
        if (IllegalCount !== expIllCnt()) begin
          miscompares++;
          $display("FAIL ill_count_mid: got %0d, want %0d", IllegalCount, expIllCnt());
        end
      end
    end
    InValid = 1'b0;
    step();
    vectors++;
    if (IllegalCount !== 8'd255) begin
      miscompares++;
      $display("FAIL ill_count_sat: got %0d, want 255", IllegalCount);
    end
  endtask

  task automatic test_async_reset();
    OutReady = 1'b0;
    for (int v = 7; v <= 9; v++) begin
      InValid = 1'b1; OpCode = 3'b001; Result = 4'(v); Cout = 1'b0;
      step();
    end
    InValid = 1'b0;
    vectors++;
    if (Count !== 3'd3) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %0d, want 3", Count);
    end
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || IllegalCount !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: Count=%0d V=%b Ill=%0d, want 0 0 0",
               Count, OutValid, IllegalCount);
    end
    q.delete(); illCnt = 0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    vectors++;
    if (InReady !== 1'b1 || Count !== 3'd0) begin
      miscompares++;
      $display("FAIL after_reset: InReady=%b Count=%0d, want 1 0", InReady, Count);
    end
    OutReady = 1'b1;
    InValid = 1'b1; OpCode = 3'b001; Result = 4'd5; Cout = 1'b0;
    step();
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b1 || OutResult !== 4'd5 || OutCarry !== 1'b0 || OutZero !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_add: V=%b res=%0d c=%b z=%b, want 1 5 0 0",
               OutValid, OutResult, OutCarry, OutZero);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_or();
    test_illegal();
    test_back_to_back();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Downstream stage of the 4-bit combinational ALU. Each cycle it can accept one ALU result: the opcode, the 4-bit Result and the carry-out. It derives status flags, sanitises undefined outputs and buffers the entries in a small FIFO. Consumers read the entries through a valid/ready handshake. It also keeps a saturating count of illegal-opcode results for debug.

Parameters:
WIDTH, 4, data width of Result; must match the ALU operand width.
DEPTH, 4, number of FIFO entries; power of two, at least 2.
CNT_W, 8, width of IllegalCount.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
InValid  input  1  OpCode/Result/Cout are valid this cycle
InReady  output  1  stage can accept an entry; equals (Count < DEPTH)
OpCode  input  3  opcode that produced Result
Result  input  WIDTH  ALU result; may be Z/X for illegal opcodes
Cout  input  1  carry-out; meaningful only for ADD and SUB
OutValid  output  1  head entry is valid
OutReady  input  1  consumer takes the head entry
OutOpCode  output  3  opcode of the head entry
OutResult  output  WIDTH  sanitised result of the head entry
OutCarry  output  1  carry flag of the head entry
OutZero  output  1  zero flag of the head entry
OutIllegal  output  1  head entry came from an illegal opcode
Count  output  log2(DEPTH)+1  current occupancy
IllegalCount  output  CNT_W  saturating count of accepted illegal entries

Behaviour:
- Interface: one clock, Clk; Reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-transfer):
  - FIFO emptied; Count=0, OutValid=0, IllegalCount=0.
  - OutOpCode/OutResult/OutCarry/OutZero/OutIllegal all 0.
  - InReady=1 in the first cycle after Reset deasserts.
- Push: when InValid && InReady. Pop: when OutValid && OutReady.
- Entry formation on push, combinational from the inputs:
  - Legal opcodes: 000 SUB, 001 ADD, 010 OR, 011 AND. Opcodes 1xx are illegal.
  - Illegal: stored Result=0, Carry=0, Zero=0, Illegal=1. Z/X on the Result inputs must never propagate.
  - SUB/ADD: Carry=Cout (for SUB, 1 means no borrow).
  - OR/AND: Carry=0; Cout is ignored.
  - Legal opcodes: Zero=(Result==0), Illegal=0.
- Latency:
  - A pushed entry appears on the Out* ports the cycle after acceptance when the FIFO was empty.
  - Otherwise it appears when it reaches the head.
  - Out* ports are registered or driven from FIFO storage, never combinational from the In* ports.
- Ordering: strict FIFO order.
- Out* hold stable while OutValid=1 && OutReady=0.
- When OutValid=0, Out* hold their last-popped values. The bench ignores them in this state.
- Full (Count==DEPTH):
  - InReady=0 and pushes are refused.
  - InReady does not depend on OutReady in the same cycle; a simultaneous pop does not enable a push.
- Empty: OutValid=0; OutReady is ignored.
- Simultaneous push and pop when 0<Count<DEPTH: Count unchanged; both take effect.
- Pointers: wrap modulo DEPTH. Count ranges 0..DEPTH.
- IllegalCount: increments on every pushed illegal entry and saturates at 2^CNT_W-1. Refused pushes do not count.
- InValid with InReady=0: nothing is stored. The upstream must hold its data stable.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_SUB=3'b000, OP_ADD=3'b001, OP_OR=3'b010, OP_AND=3'b011;
  - a packed entry type {opcode[2:0], result[WIDTH-1:0], carry, zero, illegal};
  - a function is_legal_op.
- Sub-module alu_result_fifo: a generic DEPTH-entry synchronous FIFO with count, full and empty. The top level contains only flag derivation, sanitisation and IllegalCount.

Test Plan:
- ADD, Result=4'h1, Cout=1 (9+8), OutReady=1 → next cycle OutValid=1, OutResult=1, OutCarry=1, OutZero=0, OutIllegal=0.
- SUB, Result=4'h0, Cout=1 (5-5) → OutResult=0, OutZero=1, OutCarry=1. OR, Result=4'hF, Cout=1 → OutCarry=0, OutZero=0.
- OpCode=3'b101, Result=4'bzzzz → OutResult=4'h0, OutIllegal=1, OutCarry=0, IllegalCount=1.
- OutReady=0 with 5 back-to-back pushes of values 1..5:
  - after the 4th push, Count=4 and InReady=0; value 5 is held upstream;
  - then OutReady=1 → values pop in order 1,2,3,4 and value 5 is accepted after the first pop;
  - when OutReady=1 and 0<Count<DEPTH, a push in the same cycle as a pop leaves Count unchanged.
- 300 consecutive illegal pushes → IllegalCount saturates at 255.
- Assert Reset asynchronously mid-cycle with Count=3 → Count=0, OutValid=0 and IllegalCount=0 immediately. After release, a single ADD 2+3 (Result=5) → OutResult=5.
